proj_minhash_reduce: RTL

Streaming MinHash reduction stage directly downstream of the projected feature-map RAM. Each cycle it accepts the multi-lane read word that the RAM produces (one DATA_BITS word per read address), hashes each lane with a per-lane universal hash, and keeps a running unsigned minimum per lane over a window of WINDOW beats. At window end it emits the LANES-wide signature through a valid/ready output register, flagging any signature lost to back-pressure.

---
 rtl/proj_minhash_pkg.sv | 38 +++
 rtl/proj_minhash_lane.sv | 36 +++
 rtl/proj_minhash_reduce.sv | 105 ++++++++++
 3 files changed

// File: rtl/proj_minhash_pkg.sv
// Shared constants and helpers for the MinHash reduction stage: per-lane hash
// seeds/multipliers, the lane hash function and the output-holder state type.
package proj_minhash_pkg;

    localparam int MAX_LANES = 16;

    localparam logic [31:0] SEED [MAX_LANES] = '{
        32'h9E3779B9, 32'h7F4A7C15, 32'hF39CC060, 32'h5CEDC834,
        32'h2C1B3C6D, 32'h297A2D39, 32'hA1B2C3D4, 32'h1B873593,
        32'hCC9E2D51, 32'h61C88647, 32'hD6E8FEB8, 32'h3C6EF372,
        32'hA54FF53A, 32'h510E527F, 32'h9B05688C, 32'h1F83D9AB
    };

    // Every multiplier is odd, so each hash is a bijection on the lane word.
    localparam logic [31:0] MULT [MAX_LANES] = '{
        32'h85EBCA6B, 32'hC2B2AE35, 32'h27D4EB2F, 32'h165667B1,
        32'hD3A2646D, 32'hFD7046C5, 32'hB55A4F09, 32'h2545F491,
        32'h9E3779B1, 32'h7FEB352D, 32'h846CA68B, 32'h6C8E9CF5,
        32'hE6546B65, 32'h5BD1E995, 32'h68E31DA5, 32'hBF58476D
    };

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    // Universal hash ((x ^ seed) * mult) truncated to 'bits' LSBs (bits <= 32).
    function automatic logic [31:0] minhash_fn(input logic [31:0] x,
                                               input int          lane,
                                               input int          bits);
        logic [31:0] mask;
        logic [63:0] prod;
        mask = (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        prod = 64'((x ^ SEED[lane]) & mask) * 64'(MULT[lane] & mask);
        return prod[31:0] & mask;
    endfunction

endpackage

// File: rtl/proj_minhash_lane.sv
// One MinHash lane: hashes the incoming lane word and keeps the running
// unsigned minimum of the current window.
module proj_minhash_lane
    import proj_minhash_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int LANE_IDX  = 0,
    parameter bit HASH_EN   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 beat,
    input  logic                 first,
    input  logic [DATA_BITS-1:0] data,
    output logic [DATA_BITS-1:0] merged
);

    logic [DATA_BITS-1:0] hashed;
    logic [DATA_BITS-1:0] acc_q;

    // merged is the window minimum including this cycle's beat; the top level
    // captures it directly at window end so no extra cycle is spent.
    always_comb begin
        hashed = HASH_EN ? DATA_BITS'(minhash_fn(32'(data), LANE_IDX, DATA_BITS)) : data;
        merged = (first || (hashed < acc_q)) ? hashed : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (beat) begin
            acc_q <= merged;
        end
    end

endmodule

// File: rtl/proj_minhash_reduce.sv
// Streaming MinHash reduction: per-lane hash + windowed minimum, with the
// finished signature held in a valid/ready register and a sticky drop flag.
module proj_minhash_reduce
    import proj_minhash_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int DATA_BITS = 8,
    parameter int WINDOW    = 16,
    parameter bit HASH_EN   = 1'b1,
    localparam int CNT_W    = $clog2(WINDOW)
) (
    input  logic                       in_clk,
    input  logic                       in_rst_n,
    input  logic                       in_valid,
    input  logic [LANES*DATA_BITS-1:0] in_data,
    input  logic                       in_restart,
    input  logic                       in_sig_ready,
    output logic [LANES*DATA_BITS-1:0] out_sig,
    output logic                       out_valid,
    output logic                       out_overflow,
    output logic [CNT_W-1:0]           out_beat_cnt
);

    logic [CNT_W-1:0]           cnt_q;
    logic [LANES*DATA_BITS-1:0] merged_sig;
    logic                       window_start;
    logic                       completion;
    out_state_e                 state_q;
    out_state_e                 state_d;
    logic                       load_sig;
    logic                       set_ovf;

    // A restart turns the current beat (if any) into beat 0 of a new window.
    assign window_start = in_restart || (cnt_q == '0);
    assign completion   = in_valid && !in_restart && (cnt_q == CNT_W'(WINDOW - 1));

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        proj_minhash_lane #(
            .DATA_BITS (DATA_BITS),
            .LANE_IDX  (i),
            .HASH_EN   (HASH_EN)
        ) u_lane (
            .clk    (in_clk),
            .rst_n  (in_rst_n),
            .beat   (in_valid),
            .first  (window_start),
            .data   (in_data[i*DATA_BITS +: DATA_BITS]),
            .merged (merged_sig[i*DATA_BITS +: DATA_BITS])
        );
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            cnt_q <= '0;
        end else if (in_restart) begin
            cnt_q <= in_valid ? CNT_W'(1) : '0;
        end else if (in_valid) begin
            cnt_q <= completion ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // A new signature always wins the holder; dropping an unread one is flagged.
    always_comb begin
        state_d  = state_q;
        load_sig = 1'b0;
        set_ovf  = 1'b0;
        case (state_q)
            EMPTY: begin
                if (completion) begin
                    state_d  = FULL;
                    load_sig = 1'b1;
                end
            end
            FULL: begin
                if (completion) begin
                    load_sig = 1'b1;
                    set_ovf  = !in_sig_ready;
                end else if (in_sig_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q      <= EMPTY;
            out_sig      <= '0;
            out_overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_sig) begin
                out_sig <= merged_sig;
            end
            if (set_ovf) begin
                out_overflow <= 1'b1;
            end
        end
    end

    assign out_valid    = (state_q == FULL);
    assign out_beat_cnt = cnt_q;

endmodule
